// File: rtl/chan_mux_rr.sv
// N-channel registered mux with direct select and TDM scan modes.
// Define CHAN_MUX_RR_SKIP_EN to make scan mode work-conserving round-robin.
module chan_mux_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] chan_q, chan_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          valid_q, valid_d;

    logic          load_en;
    logic          xfer;
    logic [SW-1:0] cand;
    logic          cand_ok;
    logic [SW-1:0] pick;
    logic          pick_ok;
    logic [W-1:0]  pick_data;
    logic [SW-1:0] pick_nxt;
    logic [SW-1:0] ptr_nxt;

    assign load_en = !valid_q || out_ready;

`ifdef CHAN_MUX_RR_SKIP_EN
    // Descending search so the nearest valid channel from ptr wins.
    always_comb begin
        cand    = ptr_q;
        cand_ok = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[(int'(ptr_q) + k) % N]) begin
                cand    = SW'((int'(ptr_q) + k) % N);
                cand_ok = 1'b1;
            end
        end
    end
`else
    assign cand    = ptr_q;
    assign cand_ok = 1'b1;
`endif

    assign pick    = mode ? cand : sel;
    assign pick_ok = mode ? cand_ok : (int'(sel) < N);

    always_comb begin
        in_ready  = '0;
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(pick) == i) begin
                in_ready[i] = rst_n && load_en && pick_ok;
                pick_data   = in_data[i*W +: W];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    assign pick_nxt = (pick == SW'(N - 1)) ? '0 : pick + 1'b1;
    assign ptr_nxt  = (ptr_q == SW'(N - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            valid_d = xfer;
            if (xfer) begin
                data_d = pick_data;
                chan_d = pick;
            end
`ifdef CHAN_MUX_RR_SKIP_EN
            if (mode && xfer) ptr_d = pick_nxt;
`else
            if (mode) ptr_d = ptr_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Bench for chan_mux_rr: directed plan items plus random traffic
// against a slot/arbitration reference model.
module tb_chan_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        rst3_n;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;

    int n_tests = 0;
    int n_fail  = 0;

    logic       m_valid;
    logic [7:0] m_data;
    int         m_chan;
    int         m_ptr;

    always #5 clk = ~clk;

    chan_mux_rr #(.N(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    chan_mux_rr #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3),
        .mode(mode3), .sel(sel3),
        .out_data(out_data3), .out_chan(out_chan3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, obs, exp);
        end
    endtask

    // Which channel may transfer this cycle, from the rules.
    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        logic       found;
        int         c;
        r = '0;
        if (!rst_n) return r;
        if (m_valid && !out_ready) return r;
        if (!mode) begin
            r[sel] = 1'b1;
        end else begin
`ifdef CHAN_MUX_RR_SKIP_EN
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && in_valid[c]) begin
                    r[c]  = 1'b1;
                    found = 1'b1;
                end
            end
`else
            found = 1'b0;
            c     = 0;
            r[m_ptr] = 1'b1;
`endif
        end
        return r;
    endfunction

    task automatic cycle();
        logic [3:0] er;
        logic [3:0] take;
        int         ch;
        er = exp_ready();
        #1;
        check("in_ready", 32'(in_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_chan", 32'(out_chan), 32'(m_chan));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_ptr   = 0;
        end else if (!m_valid || out_ready) begin
            take = in_valid & er;
            ch   = -1;
            for (int i = 0; i < 4; i++)
                if (take[i]) ch = i;
            m_valid = (ch >= 0);
            if (ch >= 0) begin
                m_data = in_data[ch*8 +: 8];
                m_chan = ch;
            end
`ifdef CHAN_MUX_RR_SKIP_EN
            if (mode && ch >= 0) m_ptr = (ch + 1) % 4;
`else
            if (mode) m_ptr = (m_ptr + 1) % 4;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
        rst_n = 1'b0; in_data = '0; in_valid = '0;
        mode = 1'b0; sel = '0; out_ready = 1'b1;
        rst3_n = 1'b0; in_data3 = '0; in_valid3 = '0;
        mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
        @(negedge clk);

        // reset
        cycle();
        cycle();
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_chan", 32'(out_chan), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        // direct select
        rst_n = 1'b1; mode = 1'b0; sel = 2'd2;
        in_data = 32'h44332211; in_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        check("dir_ready", 32'(in_ready), 32'h4);
        cycle();
        check("dir_data", 32'(out_data), 32'h33);
        check("dir_chan", 32'(out_chan), 32'h2);
        check("dir_valid", 32'(out_valid), 32'h1);

        // backpressure
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel     = 2'($urandom);
            in_data = $urandom;
            cycle();
            check("bp_data", 32'(out_data), 32'h33);
            check("bp_chan", 32'(out_chan), 32'h2);
        end
        out_ready = 1'b1; sel = 2'd0; in_valid = 4'b0001;
        cycle();
        check("rel_chan", 32'(out_chan), 32'h0);
        check("rel_data", 32'(out_data), 32'(in_data[7:0]));

        // scan
        mode = 1'b1; in_valid = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            cycle();
`ifdef CHAN_MUX_RR_SKIP_EN
            check("rr_valid", 32'(out_valid), 32'h1);
            check("rr_chan", 32'(out_chan),
                  (k % 2 == 0) ? 32'h1 : 32'h3);
`else
            check("tdm_valid", 32'(out_valid), 32'(k % 2));
            if (k % 2 == 1)
                check("tdm_chan", 32'(out_chan),
                      (k % 4 == 1) ? 32'h1 : 32'h3);
`endif
        end
        in_valid = 4'b0000;
        cycle();
        cycle();
        check("scan_idle", 32'(out_valid), 32'h0);

        // reset mid-stream
        in_valid = 4'b1111;
        cycle();
        cycle();
        check("mid_pre", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        cycle();
        check("mid_rst", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        cycle();
        check("mid_chan", 32'(out_chan), 32'h0);
        check("mid_valid", 32'(out_valid), 32'h1);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            rst_n     = ($urandom % 60) != 0;
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom % 4) != 0;
            cycle();
        end

        // N = 3, out-of-range select
        rst3_n = 1'b1; mode3 = 1'b0; sel3 = 2'd3;
        in_valid3 = 3'b111; in_data3 = 24'hCCBBAA;
        #1;
        check("n3_ready", 32'(in_ready3), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("n3_novalid", 32'(out_valid3), 32'h0);
        sel3 = 2'd1;
        #1;
        check("n3_ready1", 32'(in_ready3), 32'h2);
        @(posedge clk);
        @(negedge clk);
        check("n3_data", 32'(out_data3), 32'hBB);
        check("n3_chan", 32'(out_chan3), 32'h1);
        sel3 = 2'd2;
        @(posedge clk);
        @(negedge clk);
        check("n3_data2", 32'(out_data3), 32'hCC);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input channel and on the output. It selects either a software-chosen channel (direct mode) or cycles through channels automatically (scan mode), and registers the result with its channel tag. It sits between parallel data sources and a single shared downstream consumer.

## Interface
- N, default 4: channel count, N >= 2 (need not be a power of two)
- W, default 8: data width per channel, W >= 1
- SW (localparam): $clog2(N), the select and tag width

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_valid  input  N  channel i holds data
- in_ready  output  N  channel i transfer accepted this cycle (combinational)
- mode  input  1  0 = direct, 1 = scan
- sel  input  SW  channel index used in direct mode
- out_data  output  W  registered selected data
- out_chan  output  SW  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_chan valid
- out_ready  input  1  consumer accepts out_data

## Operation
- Single output register stage; load_en = !out_valid || out_ready.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]; at most one in_ready bit is high per cycle.
- On transfer: out_data <= channel data, out_chan <= i, out_valid <= 1.
- If load_en and no transfer: out_valid <= 0. If !load_en: output registers hold.
- Direct mode: in_ready[i] = rst_n && load_en && (i == sel). When sel >= N, all in_ready are 0 and no transfer occurs.
- Scan mode: internal pointer ptr (SW bits) names the candidate channel; in_ready[ptr] = rst_n && load_en.
- Scan, default build: ptr advances on every load_en cycle, whether or not the channel was valid (fixed TDM slots). Wrap: N-1 -> 0.
- ptr holds in direct mode and while !load_en. It is not cleared on a mode change.
- mode and sel are sampled each cycle; a change takes effect on the same cycle's selection, with no pipeline flush.
- Reset (rst_n low at an edge): out_data = 0, out_chan = 0, out_valid = 0, ptr = 0. While rst_n is low, in_ready = 0.
- Reset asserted while out_valid = 1 discards the held word. The consumer must not see a completed transfer in that cycle.

## Timing
- Latency: input transfer at edge k produces out_valid = 1 after edge k, so the data is visible in cycle k+1.
- Throughput: one word per cycle while out_ready is held at 1.
- Backpressure: when out_valid = 1 and out_ready = 0, all in_ready = 0, out_data, out_chan and out_valid are stable, and ptr does not move.
- in_ready depends combinationally on out_valid, out_ready, mode, sel, ptr (and on in_valid under the macro). It never depends on in_data.

## Configuration
- CHAN_MUX_RR_SKIP_EN defined: in scan mode the candidate is the first channel c with in_valid[c] = 1, searching cyclically from ptr. On transfer, ptr <= (c+1) mod N. With no valid channel, no transfer occurs and ptr holds. This gives work-conserving round-robin arbitration.
- Not defined: fixed TDM scan as described in Operation. Empty slots cost one cycle each.
- Direct mode is identical in both builds.

## Test plan
- Reset/direct: hold rst_n = 0 for 2 cycles, expect all outputs 0. Then rst_n = 1, mode = 0, sel = 2, in_data = {8'h44, 8'h33, 8'h22, 8'h11}, in_valid = 4'b0100, out_ready = 1. Expect in_ready = 4'b0100; next cycle out_data = 8'h33, out_chan = 2, out_valid = 1.
- Backpressure: with out_valid = 1, drive out_ready = 0 for 3 cycles while changing sel and in_data. Expect out_data, out_chan and out_valid unchanged and in_ready = 0; on release, the next word loads.
- TDM scan (default build): mode = 1, in_valid = 4'b1010, out_ready = 1. Expect out_chan sequence 1, 3, 1, 3 with out_valid pattern 0, 1, 0, 1 aligned to slots, and ptr wrapping 3 -> 0.
- Round-robin scan (CHAN_MUX_RR_SKIP_EN): same stimulus. Expect out_valid = 1 every cycle and out_chan = 1, 3, 1, 3. With in_valid = 0, ptr holds and out_valid = 0.
- Boundary: N = 3, mode = 0, sel = 3, in_valid = 3'b111. Expect in_ready = 0 and no transfer.
- Reset mid-stream: assert rst_n = 0 during scan with out_valid = 1. Expect out_valid = 0 and ptr = 0 after the edge; the first accepted channel after release is channel 0.
